// File: rtl/snake_pkg.sv
// Shared encodings and screen constants for the snake game video path.
// Imported by every block that renders or sequences game state.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } master_state_t;

    localparam logic [7:0] COLOUR_BLACK = 8'h00;
    localparam logic [7:0] COLOUR_RED   = 8'hE0;
    localparam logic [7:0] COLOUR_BLUE  = 8'h03;

    localparam int GRID_H_DEFAULT = 160;
    localparam int GRID_V_DEFAULT = 120;

    localparam logic [9:0] PIXEL_H_LIMIT = 10'd640;
    localparam logic [8:0] PIXEL_V_LIMIT = 9'd480;

    // One captured pixel request as it travels from stage 0 to stage 1.
    typedef struct packed {
        logic          valid;
        logic [9:0]    addrh;
        logic [8:0]    addrv;
        logic          snake_hit;
        logic [7:0]    snake_colour;
        logic [7:0]    target_h;
        logic [6:0]    target_v;
        master_state_t state;
    } pixel_req_t;

    function automatic logic pixel_in_range(input logic [9:0] addrh, input logic [8:0] addrv);
        return (addrh < PIXEL_H_LIMIT) && (addrv < PIXEL_V_LIMIT);
    endfunction

endpackage

// File: rtl/frame_tick_counter.sv
// Counts VS falling edges into an 8-bit wrapping frame counter; any change
// of master state restarts the count so every screen animates from frame 0.
module frame_tick_counter
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       vs,
    input  logic [1:0] master_state,
    output logic [7:0] frame_cnt
);

    logic       vs_q;
    logic [1:0] state_reg;
    logic [7:0] frame_cnt_reg;

    assign frame_cnt = frame_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q          <= 1'b1;
            state_reg     <= ST_IDLE;
            frame_cnt_reg <= 8'd0;
        end else begin
            vs_q      <= vs;
            state_reg <= master_state;
            // A state change outranks a coincident frame edge.
            if (master_state != state_reg)
                frame_cnt_reg <= 8'd0;
            else if (vs_q && !vs)
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
        end
    end

endmodule

// File: rtl/pixel_colour_server.sv
// Answers VGA pixel requests with an RGB332 colour two cycles later, drawing
// the idle/play/win/lose screens and merging the snake body.
module pixel_colour_server
    import snake_pkg::*;
#(
    parameter int GRID_H    = GRID_H_DEFAULT,
    parameter int GRID_V    = GRID_V_DEFAULT,
    parameter int BLINK_BIT = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MASTER_STATE,
    input  logic       VS,
    input  logic       ADDR_VALID,
    input  logic [9:0] ADDRH,
    input  logic [8:0] ADDRV,
    input  logic [7:0] TARGET_H,
    input  logic [6:0] TARGET_V,
    input  logic       SNAKE_HIT,
    input  logic [7:0] SNAKE_COLOUR,
    output logic [7:0] COLOUR,
    output logic       COLOUR_VALID
);

    localparam logic [7:0] LAST_CELL_H = 8'(GRID_H - 1);
    localparam logic [6:0] LAST_CELL_V = 7'(GRID_V - 1);

    pixel_req_t s0_reg;
    logic [7:0] frame_cnt;
    logic [7:0] cell_h;
    logic [6:0] cell_v;
    logic       border_cell;
    logic       target_cell;
    logic [7:0] colour_next;
    logic       colour_valid_next;
    logic [7:0] colour_reg;
    logic       colour_valid_reg;

    // The counter watches the live state so a change clears it in the same
    // cycle the new state enters stage 0.
    frame_tick_counter u_frame_tick_counter (
        .clk          (CLK),
        .rst_n        (RESET),
        .vs           (VS),
        .master_state (MASTER_STATE),
        .frame_cnt    (frame_cnt)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            s0_reg <= '0;
        end else begin
            s0_reg.valid        <= ADDR_VALID;
            s0_reg.addrh        <= ADDRH;
            s0_reg.addrv        <= ADDRV;
            s0_reg.snake_hit    <= SNAKE_HIT;
            s0_reg.snake_colour <= SNAKE_COLOUR;
            s0_reg.target_h     <= TARGET_H;
            s0_reg.target_v     <= TARGET_V;
            s0_reg.state        <= master_state_t'(MASTER_STATE);
        end
    end

    assign cell_h      = s0_reg.addrh[9:2];
    assign cell_v      = s0_reg.addrv[8:2];
    assign border_cell = (cell_h == 8'd0) || (cell_h == LAST_CELL_H) ||
                         (cell_v == 7'd0) || (cell_v == LAST_CELL_V);
    assign target_cell = (cell_h == s0_reg.target_h) && (cell_v == s0_reg.target_v);

    always_comb begin
        colour_next       = COLOUR_BLACK;
        colour_valid_next = 1'b0;
        if (s0_reg.valid) begin
            colour_valid_next = 1'b1;
            if (pixel_in_range(s0_reg.addrh, s0_reg.addrv)) begin
                case (s0_reg.state)
                    ST_IDLE: colour_next = cell_h + frame_cnt;
                    ST_PLAY: begin
                        if (border_cell)
                            colour_next = COLOUR_BLUE;
                        else if (s0_reg.snake_hit)
                            colour_next = s0_reg.snake_colour;
                        else if (target_cell)
                            colour_next = frame_cnt[BLINK_BIT] ? COLOUR_BLACK : COLOUR_RED;
                        else
                            colour_next = COLOUR_BLACK;
                    end
                    ST_WIN:  colour_next = frame_cnt;
                    ST_LOSE: colour_next = frame_cnt[4] ? COLOUR_BLACK : COLOUR_RED;
                    default: colour_next = COLOUR_BLACK;
                endcase
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            colour_reg       <= COLOUR_BLACK;
            colour_valid_reg <= 1'b0;
        end else begin
            colour_reg       <= colour_next;
            colour_valid_reg <= colour_valid_next;
        end
    end

    assign COLOUR       = colour_reg;
    assign COLOUR_VALID = colour_valid_reg;

endmodule

// File: tb/tb_pixel_colour_server.sv
// Scoreboard bench: a frame-level reference model predicts each response,
// a negedge monitor compares the DUT output two cycles after the request.
module tb_pixel_colour_server;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [1:0] MASTER_STATE = 2'd0;
    logic       VS = 1'b1;
    logic       ADDR_VALID = 1'b0;
    logic [9:0] ADDRH = '0;
    logic [8:0] ADDRV = '0;
    logic [7:0] TARGET_H = '0;
    logic [6:0] TARGET_V = '0;
    logic       SNAKE_HIT = 1'b0;
    logic [7:0] SNAKE_COLOUR = '0;
    logic [7:0] COLOUR;
    logic       COLOUR_VALID;

    pixel_colour_server dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .MASTER_STATE (MASTER_STATE),
        .VS           (VS),
        .ADDR_VALID   (ADDR_VALID),
        .ADDRH        (ADDRH),
        .ADDRV        (ADDRV),
        .TARGET_H     (TARGET_H),
        .TARGET_V     (TARGET_V),
        .SNAKE_HIT    (SNAKE_HIT),
        .SNAKE_COLOUR (SNAKE_COLOUR),
        .COLOUR       (COLOUR),
        .COLOUR_VALID (COLOUR_VALID)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] colour;
        logic       valid;
        string      tag;
    } exp_t;

    exp_t  sb_q[$];
    int    tests_run = 0;
    int    tests_failed = 0;
    string cur_tag = "reset";

    int model_cnt = 0;
    int model_prev_vs = 1;
    int model_prev_state = 0;

    // Screen rules written directly in pixel/cell arithmetic.
    function automatic logic [7:0] ref_colour(input int state, input int cnt, input int h, input int v,
                                              input int hit, input int scol, input int th, input int tv);
        int ch, cv;
        if (h >= 640 || v >= 480) return 8'h00;
        ch = h / 4;
        cv = v / 4;
        case (state)
            0: return 8'((ch + cnt) % 256);
            1: begin
                if (ch == 0 || ch == 159 || cv == 0 || cv == 119) return 8'h03;
                if (hit != 0) return 8'(scol);
                if (ch == th && cv == tv) return ((cnt / 8) % 2 == 0) ? 8'hE0 : 8'h00;
                return 8'h00;
            end
            2: return 8'(cnt);
            default: return ((cnt / 16) % 2 == 0) ? 8'hE0 : 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] got_c, input logic got_v,
                         input logic [7:0] exp_c, input logic exp_v);
        tests_run++;
        if (got_c !== exp_c || got_v !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL %s: got colour=%02h valid=%0b, required colour=%02h valid=%0b",
                     name, got_c, got_v, exp_c, exp_v);
        end else begin
            $display("[TB] ok %s: colour=%02h valid=%0b", name, got_c, got_v);
        end
    endtask

    // Reference model: advances the frame count and predicts the response
    // for whatever request is captured at this edge.
    always @(posedge CLK) begin
        exp_t e;
        if (!RESET) begin
            model_cnt = 0;
            model_prev_vs = 1;
            model_prev_state = 0;
            sb_q.delete();
        end else begin
            if (int'(MASTER_STATE) != model_prev_state)
                model_cnt = 0;
            else if (model_prev_vs == 1 && VS == 1'b0)
                model_cnt = (model_cnt + 1) % 256;
            model_prev_vs = int'(VS);
            model_prev_state = int'(MASTER_STATE);
            e.valid = ADDR_VALID;
            e.colour = ADDR_VALID ? ref_colour(int'(MASTER_STATE), model_cnt, int'(ADDRH), int'(ADDRV),
                                               int'(SNAKE_HIT), int'(SNAKE_COLOUR),
                                               int'(TARGET_H), int'(TARGET_V)) : 8'h00;
            e.tag = cur_tag;
            sb_q.push_back(e);
        end
    end

    // Monitor: after edge k the output belongs to the request captured at edge k-1.
    always @(negedge CLK) begin
        exp_t e;
        if (RESET && sb_q.size() >= 2) begin
            e = sb_q.pop_front();
            check(e.tag, COLOUR, COLOUR_VALID, e.colour, e.valid);
        end
    end

    task automatic drive(input logic valid, input int h, input int v, input logic hit, input logic [7:0] scol);
        ADDR_VALID   = valid;
        ADDRH        = 10'(h);
        ADDRV        = 9'(v);
        SNAKE_HIT    = hit;
        SNAKE_COLOUR = scol;
        @(negedge CLK);
    endtask

    task automatic vs_edges(input int n);
        for (int i = 0; i < n; i++) begin
            ADDR_VALID = 1'b0;
            VS = 1'b0;
            @(negedge CLK);
            VS = 1'b1;
            @(negedge CLK);
        end
    endtask

    initial begin
        @(negedge CLK);
        ADDR_VALID = 1'b1;
        ADDRH = 10'd100;
        repeat (3) @(negedge CLK);
        check("reset_hold", COLOUR, COLOUR_VALID, 8'h00, 1'b0);
        RESET = 1'b1;

        cur_tag = "play_origin_border";
        MASTER_STATE = 2'd1;
        drive(1'b1, 0, 0, 1'b0, 8'h00);

        TARGET_H = 8'd10;
        TARGET_V = 7'd20;
        cur_tag = "target_frame0";
        drive(1'b1, 41, 81, 1'b0, 8'h00);
        vs_edges(8);
        cur_tag = "target_frame8";
        drive(1'b1, 41, 81, 1'b0, 8'h00);
        cur_tag = "snake_over_target";
        drive(1'b1, 41, 81, 1'b1, 8'h1C);
        cur_tag = "border_over_snake";
        drive(1'b1, 639, 200, 1'b1, 8'h1C);

        MASTER_STATE = 2'd2;
        cur_tag = "win_start";
        drive(1'b1, 100, 100, 1'b0, 8'h00);
        vs_edges(256);
        cur_tag = "win_wrap256";
        drive(1'b1, 100, 100, 1'b0, 8'h00);
        vs_edges(5);
        cur_tag = "win_5edges";
        drive(1'b1, 100, 100, 1'b0, 8'h00);

        cur_tag = "edge_with_state_change";
        MASTER_STATE = 2'd0;
        VS = 1'b0;
        drive(1'b1, 40, 50, 1'b0, 8'h00);
        VS = 1'b1;
        drive(1'b1, 40, 50, 1'b0, 8'h00);

        vs_edges(3);
        cur_tag = "idle_b2b";
        for (int h = 0; h < 640; h++)
            drive(1'b1, h, int'($urandom_range(0, 479)), 1'b0, 8'h00);

        cur_tag = "blank";
        drive(1'b0, 12, 12, 1'b0, 8'h00);
        cur_tag = "addrh_700";
        drive(1'b1, 700, 12, 1'b0, 8'h00);
        cur_tag = "addrv_480";
        drive(1'b1, 12, 480, 1'b0, 8'h00);

        MASTER_STATE = 2'd3;
        cur_tag = "lose_flash";
        for (int f = 0; f < 32; f++) begin
            drive(1'b1, int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b0, 8'h00);
            vs_edges(1);
        end

        cur_tag = "rand";
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 99) == 0) MASTER_STATE = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) begin
                TARGET_H = 8'($urandom_range(1, 158));
                TARGET_V = 7'($urandom_range(1, 118));
            end
            VS = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                drive(1'b1, int'({TARGET_H, 2'($urandom)}), int'({TARGET_V, 2'($urandom)}),
                      1'($urandom), 8'($urandom));
            else
                drive(1'($urandom_range(0, 7) != 0), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 511)), 1'($urandom), 8'($urandom));
        end
        VS = 1'b1;

        MASTER_STATE = 2'd0;
        cur_tag = "pre_reset";
        drive(1'b1, 400, 10, 1'b0, 8'h00);
        drive(1'b1, 400, 10, 1'b0, 8'h00);
        #2 RESET = 1'b0;
        #1 check("async_reset_drop", COLOUR, COLOUR_VALID, 8'h00, 1'b0);
        @(negedge CLK);
        ADDR_VALID = 1'b1;
        @(negedge CLK);
        RESET = 1'b1;
        cur_tag = "after_reset";
        MASTER_STATE = 2'd1;
        drive(1'b1, 0, 0, 1'b0, 8'h00);
        drive(1'b1, 41, 81, 1'b0, 8'h00);
        drive(1'b0, 0, 0, 1'b0, 8'h00);
        repeat (3) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pixel_colour_server.md
# pixel_colour_server

Responder side of the VGA pixel-request interface. The VGA wrapper issues pixel addresses (ADDRH/ADDRV) during active video and expects a colour back. This block answers every request with an RGB332 colour after a fixed two-cycle latency. It renders the game screen for each master state (idle, play, win, lose) and merges the snake-body hit supplied by snake control.

## Interface
Parameters:
- GRID_H, 160: playfield width in cells; a cell is 4×4 pixels.
- GRID_V, 120: playfield height in cells.
- BLINK_BIT, 3: frame-counter bit that gates target blinking, giving a 16-frame period.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- MASTER_STATE  in  2  0 = IDLE, 1 = PLAY, 2 = WIN, 3 = LOSE.
- VS  in  1  VGA vertical sync, active-low pulse. Its falling edge marks a frame.
- ADDR_VALID  in  1  high while ADDRH/ADDRV is an active-video request.
- ADDRH  in  10  pixel column, 0–639.
- ADDRV  in  9  pixel row, 0–479.
- TARGET_H  in  8  target cell column.
- TARGET_V  in  7  target cell row.
- SNAKE_HIT  in  1  requested pixel lies on the snake body. Aligned with ADDRH/ADDRV.
- SNAKE_COLOUR  in  8  colour used for snake pixels.
- COLOUR  out  8  rendered colour (RGB332), registered.
- COLOUR_VALID  out  1  COLOUR corresponds to a valid request.

## Operation
Cell coordinates are cellH = ADDRH[9:2] and cellV = ADDRV[8:2].

Frame counter:
- 8-bit counter `frame_cnt`.
- Increments once per VS falling edge and wraps 255 → 0.
- Clears to 0 on any cycle where MASTER_STATE differs from its registered copy.
- If a state change and a VS edge coincide, the state change wins: `frame_cnt` = 0.

Colour rules, evaluated in pipeline stage 1:
- **Not a request:** ADDR_VALID = 0 → COLOUR = 8'h00, COLOUR_VALID = 0.
- **Out of range:** ADDR_VALID = 1 with ADDRH ≥ 640 or ADDRV ≥ 480 → COLOUR = 8'h00, COLOUR_VALID = 1.
- **IDLE:** COLOUR = (cellH + frame_cnt) mod 256. This produces a scrolling gradient.
- **PLAY**, first matching rule wins:
  - border cell (cellH = 0, cellH = GRID_H−1, cellV = 0 or cellV = GRID_V−1) → 8'h03 (blue);
  - SNAKE_HIT → SNAKE_COLOUR;
  - target cell (cellH = TARGET_H and cellV = TARGET_V) → 8'hE0 if frame_cnt[BLINK_BIT] = 0, else 8'h00;
  - otherwise → 8'h00.
- **WIN:** COLOUR = frame_cnt, giving a whole-screen colour cycle.
- **LOSE:** COLOUR = 8'hE0 if frame_cnt[4] = 0, else 8'h00. This is a 32-frame flash.

The block has no back-pressure: one request is accepted per cycle and one response is produced per cycle.

## Timing
- **Latency:** a request presented at cycle n appears on COLOUR/COLOUR_VALID at cycle n+2.
- **Stage 0** registers ADDRH, ADDRV, ADDR_VALID, SNAKE_HIT, SNAKE_COLOUR, TARGET_H, TARGET_V and MASTER_STATE. Stage 1 registers the output.
- **VS edge detection:**
  - vs_q samples VS each cycle.
  - The edge condition is vs_q = 1 and VS = 0.
  - frame_cnt holds its new value from the following cycle.
  - Stage 1 uses the current frame_cnt.
- **MASTER_STATE changes** propagate through the pipeline with the request. Responses at n+2 reflect the state presented at n.
- **Reset values:** COLOUR = 0, COLOUR_VALID = 0, frame_cnt = 0, vs_q = 1, all pipeline registers 0.
- **Reset mid-line:** outputs drop immediately (asynchronously). The first valid response appears 2 cycles after release with ADDR_VALID = 1.

## Structure
- Shared package `snake_pkg` holds:
  - master-state encodings (IDLE, PLAY, WIN, LOSE);
  - colour constants (BLACK 8'h00, RED 8'hE0, BLUE 8'h03);
  - GRID_H and GRID_V defaults;
  - pixel limits 640 and 480.
- One sub-module, `frame_tick_counter`, contains the VS edge detector, the 8-bit wrap counter and the clear-on-state-change logic.

## Test plan
- **Reset:** hold RESET low with ADDR_VALID = 1 → COLOUR = 0 and COLOUR_VALID = 0. Release, then present PLAY with (0,0) → COLOUR = 8'h03 two cycles later.
- **PLAY priority:**
  - TARGET = (10,20) and pixel (41,81) at frame_cnt = 0 → 8'hE0.
  - Same pixel after 8 VS edges → 8'h00.
  - Same pixel with SNAKE_HIT = 1 and SNAKE_COLOUR = 8'h1C → 8'h1C.
  - Border pixel (639,200) with SNAKE_HIT = 1 → 8'h03.
- **Frame counter wrap:**
  - 256 VS edges in WIN → COLOUR returns to 8'h00.
  - 5 edges → 8'h05.
  - VS edge on the same cycle as a state change → frame_cnt = 0.
- **Back-to-back requests:** 640 consecutive IDLE addresses at frame_cnt = 3 → outputs follow with exactly 2-cycle latency, value (ADDRH[9:2] + 3) mod 256.
- **Blanking and range:**
  - ADDR_VALID = 0 → COLOUR_VALID = 0 and COLOUR = 0.
  - ADDRH = 700 with valid → COLOUR_VALID = 1 and COLOUR = 0.
- **LOSE flash:** frame_cnt 0–15 → 8'hE0; frame_cnt 16–31 → 8'h00.
